// File: rtl/source_packet_encoder_if.sv
// Command and packet-stream bundle between the host command logic, the encoder
// and network_source; the slave modport is the encoder's view.
interface source_packet_encoder_if #(
    parameter int PFX_WIDTH = 2,
    parameter int SPK_WIDTH = 8,
    parameter int RUN_WIDTH = 16
);
    localparam int PKT_WIDTH = PFX_WIDTH + SPK_WIDTH;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [RUN_WIDTH-1:0] cmd_arg;
    logic                 src_valid;
    logic                 src_ready;
    logic [PKT_WIDTH-1:0] src;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, src_ready,
        input  cmd_ready, src_valid, src
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, src_ready,
        output cmd_ready, src_valid, src
    );
endinterface

// File: rtl/source_packet_encoder.sv
// Encodes host commands (NOP/RUN/SPK/CLR) into network source packets, splitting
// long runs into chunks. Optional SOURCE_ENC_STATS_EN adds pkt_count/run_total.
module source_packet_encoder #(
    parameter int PFX_WIDTH = 2,
    parameter int SPK_WIDTH = 8,
    parameter int RUN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   arstn,
    source_packet_encoder_if.slave bus
`ifdef SOURCE_ENC_STATS_EN
    ,
    output logic [31:0]            pkt_count,
    output logic [31:0]            run_total
`endif
);
    localparam int PKT_WIDTH = PFX_WIDTH + SPK_WIDTH;
    localparam logic [RUN_WIDTH-1:0] MAXC = RUN_WIDTH'({SPK_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RUN = 2'b01,
        OP_SPK = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_SPLIT
    } state_e;

    function automatic logic [SPK_WIDTH-1:0] clip_chunk(input logic [RUN_WIDTH-1:0] n);
        return (n > MAXC) ? {SPK_WIDTH{1'b1}} : n[SPK_WIDTH-1:0];
    endfunction

    function automatic logic [PKT_WIDTH-1:0] make_pkt(input op_e op,
                                                      input logic [SPK_WIDTH-1:0] payload);
        return {PFX_WIDTH'(op), payload};
    endfunction

    state_e               r_state;
    logic [RUN_WIDTH-1:0] r_remaining;
    logic [PKT_WIDTH-1:0] r_src;
    logic                 r_src_valid;

    logic                 w_slot_free;
    logic                 w_cmd_fire;
    op_e                  w_cmd_op;
    logic [SPK_WIDTH-1:0] w_cmd_chunk;
    logic [RUN_WIDTH-1:0] w_cmd_rem;
    logic [SPK_WIDTH-1:0] w_split_chunk;
    logic [RUN_WIDTH-1:0] w_split_rem;

    assign w_slot_free   = !r_src_valid || bus.src_ready;
    assign bus.cmd_ready = (r_state == S_IDLE) && w_slot_free;
    assign w_cmd_fire    = bus.cmd_valid && bus.cmd_ready;
    assign w_cmd_op      = op_e'(bus.cmd_op);

    assign w_cmd_chunk   = clip_chunk(bus.cmd_arg);
    assign w_cmd_rem     = bus.cmd_arg - RUN_WIDTH'(w_cmd_chunk);
    assign w_split_chunk = clip_chunk(r_remaining);
    assign w_split_rem   = r_remaining - RUN_WIDTH'(w_split_chunk);

    assign bus.src       = r_src;
    assign bus.src_valid = r_src_valid;

    // NOTE: non-blocking assignments throughout, so every branch reads the
    // pre-edge values of state and slot registers regardless of statement order.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_src       <= '0;
            r_src_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_slot_free) begin
                        r_src_valid <= 1'b0;
                        if (w_cmd_fire) begin
                            unique case (w_cmd_op)
                                OP_NOP: ;
                                OP_RUN: begin
                                    if (bus.cmd_arg != '0) begin
                                        r_src       <= make_pkt(OP_RUN, w_cmd_chunk);
                                        r_src_valid <= 1'b1;
                                        r_remaining <= w_cmd_rem;
                                        if (w_cmd_rem != '0) begin
                                            r_state <= S_SPLIT;
                                        end
                                    end
                                end
                                OP_SPK: begin
                                    r_src       <= make_pkt(OP_SPK, bus.cmd_arg[SPK_WIDTH-1:0]);
                                    r_src_valid <= 1'b1;
                                end
                                OP_CLR: begin
                                    r_src       <= make_pkt(OP_CLR, '0);
                                    r_src_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_SPLIT: begin
                    // Remaining run cycles drain one chunk per free slot.
                    if (w_slot_free) begin
                        r_src       <= make_pkt(OP_RUN, w_split_chunk);
                        r_src_valid <= 1'b1;
                        r_remaining <= w_split_rem;
                        if (w_split_rem == '0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SOURCE_ENC_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_run_total;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_pkt_count <= '0;
            r_run_total <= '0;
        end else if (r_src_valid && bus.src_ready) begin
            r_pkt_count <= r_pkt_count + 32'd1;
            if (r_src[PKT_WIDTH-1:SPK_WIDTH] == PFX_WIDTH'(OP_RUN)) begin
                r_run_total <= r_run_total + 32'(r_src[SPK_WIDTH-1:0]);
            end
        end
    end

    assign pkt_count = r_pkt_count;
    assign run_total = r_run_total;
`endif
endmodule
